// File: rtl/wb_scoreboard.sv
// -----------------------------------------------------------------------------
// wb_scoreboard -- write-back side of the 16-bit, 8-entry register file.
//
// Purpose
//   Keeps a 2-bit count of outstanding writes for each register r1..r7 and
//   stalls decode on RAW hazards and on counter overflow. Merges ALU results
//   and load returns onto the single register-file write port. A load that
//   loses arbitration waits in a small FIFO, so loads commit in arrival order.
//
// Ports
//   clk, rst_n          clock; synchronous active-low reset
//   flush               synchronous clear of counters, FIFO and write port
//   iss_*               decode request (rd/rs, operand uses, writes-rd)
//   iss_stall           combinational hold for decode
//   alu_valid/addr/data ALU result (always accepted, highest priority)
//   ld_valid/addr/data  load return; ld_ready is the combinational accept
//   WB_addr/WB_data     registered register-file write port
//   RegWe               registered write enable
//
// Configuration
//   WB_BYPASS_EN  When defined, an operand with one outstanding write whose
//                 result is on the write port this cycle does not stall. The
//                 register file forwards WB_data to that operand.
// -----------------------------------------------------------------------------

// One pending-write counter. It saturates at both ends. A reserve and a
// release in the same cycle cancel.
module wb_pend_cnt (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  input  logic       dec,
  output logic [1:0] cnt_o
);
  logic [1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && !dec && cnt_q != 2'd3)      cnt_d = cnt_q + 2'd1;
    else if (dec && !inc && cnt_q != 2'd0) cnt_d = cnt_q - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) cnt_q <= 2'd0;
    else               cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

module wb_scoreboard #(
  parameter int DATA_W = 16,
  parameter int NREG   = 8,
  parameter int AW     = 3,
  parameter int LDQ_D  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_rd,
  input  logic [AW-1:0]     iss_rs,
  input  logic              iss_use_rd,
  input  logic              iss_use_rs,
  input  logic              iss_wr,
  output logic              iss_stall,
  input  logic              alu_valid,
  input  logic [AW-1:0]     alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [AW-1:0]     ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic [AW-1:0]     WB_addr,
  output logic [DATA_W-1:0] WB_data,
  output logic              RegWe
);
  localparam int PW = $clog2(LDQ_D);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [AW-1:0]     addr;
    logic [DATA_W-1:0] data;
  } ld_ent_t;

  // Reset and flush both wipe all state and make the cycle's inputs inert.
  logic clr;
  assign clr = !rst_n || flush;

  // ---------------------------------------------------------------------------
  // Write-port registers
  // ---------------------------------------------------------------------------
  logic              we_q, we_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;

  // ---------------------------------------------------------------------------
  // Pending-write tracking
  // ---------------------------------------------------------------------------
  logic [NREG-1:0][1:0] pend;
  logic [NREG-1:0]      op_rdy;
  logic                 iss_acc;

  assign pend[0] = 2'd0;  // r0 is hard-wired and never tracked

  // A release is counted one edge after the commit appears on the write port.
  // That leaves the count at 1 for the cycle in which RegWe shows the result,
  // which is the window the bypass relaxation uses.
  for (genvar r = 1; r < NREG; r++) begin : g_pend
    logic inc_r, dec_r;
    assign inc_r = iss_acc && iss_wr && (iss_rd == AW'(r));
    assign dec_r = we_q && (addr_q == AW'(r));
    wb_pend_cnt u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (flush),
      .inc   (inc_r),
      .dec   (dec_r),
      .cnt_o (pend[r])
    );
  end

  for (genvar r = 0; r < NREG; r++) begin : g_rdy
    logic byp_hit;
`ifdef WB_BYPASS_EN
    assign byp_hit = (pend[r] == 2'd1) && we_q && (addr_q == AW'(r));
`else
    assign byp_hit = 1'b0;
`endif
    assign op_rdy[r] = (pend[r] == 2'd0) || byp_hit;
  end

  // The overflow check stays strict even with bypass. A pending count of 3
  // holds a writer until the release has been counted.
  assign iss_stall = iss_valid &&
                     ((iss_use_rd && !op_rdy[iss_rd]) ||
                      (iss_use_rs && !op_rdy[iss_rs]) ||
                      (iss_wr && iss_rd != '0 && pend[iss_rd] == 2'd3));
  assign iss_acc   = iss_valid && !iss_stall && !clr;

  // ---------------------------------------------------------------------------
  // Load holding FIFO
  // ---------------------------------------------------------------------------
  ld_ent_t         fifo_q [LDQ_D];
  logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]   cnt_q;
  logic            empty, full, pop, push, direct;

  assign empty  = (cnt_q == '0);
  assign full   = (cnt_q == CW'(LDQ_D));
  // The ALU always wins. Otherwise the FIFO head goes first, so buffered loads
  // keep their order ahead of a newly arriving load.
  assign pop    = !alu_valid && !empty;
  assign direct = !alu_valid && empty && ld_valid;
  // A pop frees a slot in the same cycle, so a full FIFO can still accept.
  assign ld_ready = !full || pop || (empty && !alu_valid);
  assign push   = ld_valid && ld_ready && !direct && !clr;

  always_ff @(posedge clk) begin
    if (clr) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= '{addr: ld_addr, data: ld_data};
  end

  // ---------------------------------------------------------------------------
  // Write-port arbitration. Address and data hold when there is no winner.
  // ---------------------------------------------------------------------------
  always_comb begin
    we_d   = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    if (alu_valid) begin
      we_d   = 1'b1;
      addr_d = alu_addr;
      data_d = alu_data;
    end else if (pop) begin
      we_d   = 1'b1;
      addr_d = fifo_q[rd_ptr_q].addr;
      data_d = fifo_q[rd_ptr_q].data;
    end else if (direct) begin
      we_d   = 1'b1;
      addr_d = ld_addr;
      data_d = ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      we_q   <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign RegWe   = we_q;
  assign WB_addr = addr_q;
  assign WB_data = data_q;
endmodule

// File: tb/tb_wb_scoreboard.sv
// Directed bench for wb_scoreboard: a cycle table for arbitration, FIFO and
// flush, then hand sequences for hazard, overflow, flush and r0 corners.
module tb_wb_scoreboard;
  logic        clk = 1'b0;
  logic        rst_n, flush;
  logic        iss_valid, iss_use_rd, iss_use_rs, iss_wr;
  logic [2:0]  iss_rd, iss_rs;
  logic        iss_stall;
  logic        alu_valid, ld_valid, ld_ready;
  logic [2:0]  alu_addr, ld_addr, WB_addr;
  logic [15:0] alu_data, ld_data, WB_data;
  logic        RegWe;

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  wb_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_rs(iss_rs),
    .iss_use_rd(iss_use_rd), .iss_use_rs(iss_use_rs), .iss_wr(iss_wr),
    .iss_stall(iss_stall),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .WB_addr(WB_addr), .WB_data(WB_data), .RegWe(RegWe)
  );

  typedef struct {
    logic        rst_n, flush;
    logic        alu_v; logic [2:0] alu_a; logic [15:0] alu_d;
    logic        ld_v;  logic [2:0] ld_a;  logic [15:0] ld_d;
    logic        x_ldr, x_we; logic [2:0] x_addr; logic [15:0] x_data;
  } vec_t;

  vec_t tbl [18];

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
  endtask

  task automatic idle();
    flush = 0; iss_valid = 0; iss_rd = 0; iss_rs = 0;
    iss_use_rd = 0; iss_use_rs = 0; iss_wr = 0;
    alu_valid = 0; alu_addr = 0; alu_data = 0;
    ld_valid = 0; ld_addr = 0; ld_data = 0;
  endtask

  task automatic iss(input logic v, input logic [2:0] rd, input logic [2:0] rs,
                     input logic urd, input logic urs, input logic wr);
    iss_valid = v; iss_rd = rd; iss_rs = rs;
    iss_use_rd = urd; iss_use_rs = urs; iss_wr = wr;
  endtask

  task automatic alu(input logic v, input logic [2:0] a, input logic [15:0] d);
    alu_valid = v; alu_addr = a; alu_data = d;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    //           rst flu alu a     d        ld a     d        ldr we a     d
    tbl[0]  = '{0, 0, 1, 3'd1, 16'hAAAA, 0, 3'd0, 16'h0000, 1, 0, 3'd0, 16'h0000};
    tbl[1]  = '{1, 0, 1, 3'd2, 16'h1234, 1, 3'd5, 16'hBEEF, 1, 1, 3'd2, 16'h1234};
    tbl[2]  = '{1, 0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1, 1, 3'd5, 16'hBEEF};
    tbl[3]  = '{1, 0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1, 0, 3'd5, 16'hBEEF};
    tbl[4]  = '{1, 0, 1, 3'd1, 16'h0001, 1, 3'd3, 16'h0033, 1, 1, 3'd1, 16'h0001};
    tbl[5]  = '{1, 0, 1, 3'd1, 16'h0002, 1, 3'd4, 16'h0044, 1, 1, 3'd1, 16'h0002};
    tbl[6]  = '{1, 0, 1, 3'd1, 16'h0003, 1, 3'd6, 16'h0066, 0, 1, 3'd1, 16'h0003};
    tbl[7]  = '{1, 0, 1, 3'd1, 16'h0004, 1, 3'd6, 16'h0066, 0, 1, 3'd1, 16'h0004};
    tbl[8]  = '{1, 0, 0, 3'd0, 16'h0000, 1, 3'd6, 16'h0066, 1, 1, 3'd3, 16'h0033};
    tbl[9]  = '{1, 0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1, 1, 3'd4, 16'h0044};
    tbl[10] = '{1, 0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1, 1, 3'd6, 16'h0066};
    tbl[11] = '{1, 0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1, 0, 3'd6, 16'h0066};
    tbl[12] = '{1, 0, 0, 3'd0, 16'h0000, 1, 3'd7, 16'h0777, 1, 1, 3'd7, 16'h0777};
    tbl[13] = '{1, 0, 1, 3'd0, 16'h00F0, 0, 3'd0, 16'h0000, 1, 1, 3'd0, 16'h00F0};
    tbl[14] = '{1, 0, 1, 3'd1, 16'h0101, 1, 3'd2, 16'h0202, 1, 1, 3'd1, 16'h0101};
    tbl[15] = '{1, 0, 1, 3'd1, 16'h0102, 1, 3'd3, 16'h0303, 1, 1, 3'd1, 16'h0102};
    tbl[16] = '{1, 1, 1, 3'd4, 16'h0404, 1, 3'd5, 16'h0505, 0, 0, 3'd0, 16'h0000};
    tbl[17] = '{1, 0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1, 0, 3'd0, 16'h0000};

    idle(); rst_n = 0;
    tick(); tick();

    for (int i = 0; i < 18; i++) begin
      rst_n = tbl[i].rst_n; flush = tbl[i].flush;
      alu(tbl[i].alu_v, tbl[i].alu_a, tbl[i].alu_d);
      ld_valid = tbl[i].ld_v; ld_addr = tbl[i].ld_a; ld_data = tbl[i].ld_d;
      #2;
      chk("tbl_ld_ready", i, 32'(ld_ready), 32'(tbl[i].x_ldr));
      chk("tbl_stall", i, 32'(iss_stall), 32'd0);
      tick();
      chk("tbl_RegWe", i, 32'(RegWe), 32'(tbl[i].x_we));
      chk("tbl_WB_addr", i, 32'(WB_addr), 32'(tbl[i].x_addr));
      chk("tbl_WB_data", i, 32'(WB_data), 32'(tbl[i].x_data));
    end
    idle();

    // RAW on r3: stall until the commit; bypass releases in the RegWe cycle
    iss(1, 3'd3, 3'd0, 0, 0, 1); #2 chk("raw_wr", 0, 32'(iss_stall), 0); tick();
    iss(1, 3'd0, 3'd3, 0, 1, 0); #2 chk("raw_use", 0, 32'(iss_stall), 1); tick();
    alu(1, 3'd3, 16'h3333);      #2 chk("raw_use", 1, 32'(iss_stall), 1); tick();
    chk("raw_we", 0, 32'(RegWe), 1); chk("raw_addr", 0, 32'(WB_addr), 3);
    alu(0, 3'd0, 16'h0);         #2 chk("raw_commit_cyc", 0, 32'(iss_stall), BYP ? 0 : 1); tick();
    #2 chk("raw_after", 0, 32'(iss_stall), 0); tick();
    idle();

    // Three writes to r4 fill the counter; the 4th stalls until one release
    for (int k = 0; k < 3; k++) begin
      iss(1, 3'd4, 3'd0, 0, 0, 1); #2 chk("ovf_wr", k, 32'(iss_stall), 0); tick();
    end
    #2 chk("ovf_4th", 0, 32'(iss_stall), 1); tick();
    alu(1, 3'd4, 16'h4444); #2 chk("ovf_4th", 1, 32'(iss_stall), 1); tick();
    alu(0, 3'd0, 16'h0);    #2 chk("ovf_commit_cyc", 0, 32'(iss_stall), 1); tick();
    #2 chk("ovf_drop", 0, 32'(iss_stall), 0); tick();
    idle();

    // Flush with two buffered loads and pend[r1]=2
    iss(1, 3'd1, 3'd0, 0, 0, 1); alu(1, 3'd7, 16'h0007);
    ld_valid = 1; ld_addr = 3'd2; ld_data = 16'h0202;
    #2 chk("fl_wr", 0, 32'(iss_stall), 0); tick();
    alu(1, 3'd7, 16'h0008); ld_addr = 3'd3; ld_data = 16'h0303;
    #2 chk("fl_wr", 1, 32'(iss_stall), 0); tick();
    iss(1, 3'd0, 3'd1, 0, 1, 0); alu(1, 3'd7, 16'h0009); ld_valid = 0;
    #2 chk("fl_use", 0, 32'(iss_stall), 1); chk("fl_ldr_full", 0, 32'(ld_ready), 0); tick();
    alu(0, 3'd0, 16'h0); flush = 1; tick(); flush = 0;
    chk("fl_we", 0, 32'(RegWe), 0);
    #2 chk("fl_use", 1, 32'(iss_stall), 0); chk("fl_ldr", 0, 32'(ld_ready), 1); tick();
    chk("fl_we", 1, 32'(RegWe), 0);
    idle();

    // r0 never stalls, and a commit to r0 leaves the other counters alone
    for (int k = 0; k < 4; k++) begin
      iss(1, 3'd0, 3'd0, 1, 1, 1); #2 chk("r0_iss", k, 32'(iss_stall), 0); tick();
    end
    iss(1, 3'd6, 3'd0, 0, 0, 1); #2 chk("r6_wr", 0, 32'(iss_stall), 0); tick();
    iss(0, 3'd0, 3'd0, 0, 0, 0); alu(1, 3'd0, 16'h00F0); tick();
    chk("r0_we", 0, 32'(RegWe), 1); chk("r0_addr", 0, 32'(WB_addr), 0);
    chk("r0_data", 0, 32'(WB_data), 32'h00F0);
    alu(0, 3'd0, 16'h0);
    iss(1, 3'd0, 3'd6, 0, 1, 0); #2 chk("r6_use", 0, 32'(iss_stall), 1); tick();
    #2 chk("r6_use", 1, 32'(iss_stall), 1); tick();

    // Same-cycle reserve and release of r6 leaves pend[r6] at 1
    iss(0, 3'd0, 3'd0, 0, 0, 0); alu(1, 3'd6, 16'h6666); tick();
    chk("rr_we", 0, 32'(RegWe), 1); chk("rr_addr", 0, 32'(WB_addr), 6);
    alu(0, 3'd0, 16'h0);
    iss(1, 3'd6, 3'd0, 0, 0, 1); #2 chk("rr_wr", 0, 32'(iss_stall), 0); tick();
    iss(1, 3'd0, 3'd6, 0, 1, 0); #2 chk("rr_use", 0, 32'(iss_stall), 1); tick();
    alu(1, 3'd6, 16'h6667);      #2 chk("rr_use", 1, 32'(iss_stall), 1); tick();
    alu(0, 3'd0, 16'h0);         #2 chk("rr_commit_cyc", 0, 32'(iss_stall), BYP ? 0 : 1); tick();
    #2 chk("rr_after", 0, 32'(iss_stall), 0); tick();
    idle(); tick();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
